// File: rtl/store_queue_pkg.sv
// Shared types for the store-side memory path: bus sizes, unaligned store kinds,
// the formatted store entry and the issue FSM states.
package store_queue_pkg;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef enum logic [1:0] {
        NO_MISALIGN = 2'd0,
        MEML        = 2'd1,
        MEMR        = 2'd2
    } misalign_mem_t;

    typedef struct packed {
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } sq_state_t;

endpackage

// File: rtl/store_queue_format.sv
// Combinational store formatter: places rt into its byte lanes and derives strobe,
// bus size and aligned address; mirror of the load alignment unit.
module store_format
    import store_queue_pkg::*;
(
    input  msize_t        msize,
    input  misalign_mem_t memtype,
    input  logic [31:0]   addr,
    input  logic [31:0]   rt,
    output store_entry_t  entry,
    output logic          misaligned
);

    logic [1:0] a;
    assign a = addr[1:0];

    // SWL/SWR are never misaligned; only naturally sized SH/SW check alignment.
    assign misaligned = ((msize == MSIZE2) && addr[0]) ||
                        ((msize == MSIZE4) && (memtype == NO_MISALIGN) && (a != 2'd0));

    always_comb begin
        entry.addr   = {addr[31:2], 2'b00};
        entry.size   = MSIZE4;
        entry.strobe = 4'b1111;
        entry.data   = rt;
        case (memtype)
            MEML: begin
                case (a)
                    2'd0: begin entry.strobe = 4'b0001; entry.data = rt >> 24; end
                    2'd1: begin entry.strobe = 4'b0011; entry.data = rt >> 16; end
                    2'd2: begin entry.strobe = 4'b0111; entry.data = rt >> 8;  end
                    default: begin entry.strobe = 4'b1111; entry.data = rt; end
                endcase
            end
            MEMR: begin
                case (a)
                    2'd0: begin entry.strobe = 4'b1111; entry.data = rt;       end
                    2'd1: begin entry.strobe = 4'b1110; entry.data = rt << 8;  end
                    2'd2: begin entry.strobe = 4'b1100; entry.data = rt << 16; end
                    default: begin entry.strobe = 4'b1000; entry.data = rt << 24; end
                endcase
            end
            default: begin
                case (msize)
                    MSIZE1: begin
                        entry.addr   = addr;
                        entry.size   = MSIZE1;
                        entry.strobe = 4'b0001 << a;
                        entry.data   = {4{rt[7:0]}};
                    end
                    MSIZE2: begin
                        entry.addr   = addr;
                        entry.size   = MSIZE2;
                        entry.strobe = a[1] ? 4'b1100 : 4'b0011;
                        entry.data   = {2{rt[15:0]}};
                    end
                    default: begin
                        entry.size   = MSIZE4;
                        entry.strobe = 4'b1111;
                        entry.data   = rt;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/store_queue.sv
// Committed-store FIFO: formats incoming stores, buffers them and issues the head
// entry on the data bus with an addr_ok / data_ok two-phase handshake.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    input  msize_t            in_msize,
    input  misalign_mem_t     in_memtype,
    output logic              ades,
    output logic              dreq_valid,
    output logic [31:0]       dreq_addr,
    output msize_t            dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [31:0]       dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    store_entry_t     mem [DEPTH];
    store_entry_t     fmt_entry;
    store_entry_t     head_entry;
    logic             fmt_misaligned;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    sq_state_t        state;
    logic             enq;
    logic             deq;

    store_format u_format (
        .msize      (in_msize),
        .memtype    (in_memtype),
        .addr       (in_addr),
        .rt         (in_data),
        .entry      (fmt_entry),
        .misaligned (fmt_misaligned)
    );

    assign ades     = in_valid & fmt_misaligned;
    assign in_ready = (count != CNT_W'(DEPTH));
    assign enq      = in_valid & in_ready & ~fmt_misaligned;
    // data_ok only completes a store once its address phase has been accepted.
    assign deq      = ((state == REQ)  & dresp_addr_ok & dresp_data_ok) |
                      ((state == WAIT) & dresp_data_ok);
    assign empty    = (count == '0) && (state == IDLE);

    // Entry storage carries no reset; occupancy is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[tail] <= fmt_entry;
        end
    end

    assign head_entry  = mem[head];
    assign dreq_addr   = head_entry.addr;
    assign dreq_size   = head_entry.size;
    assign dreq_strobe = head_entry.strobe;
    assign dreq_data   = head_entry.data;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (deq) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Issue FSM; dreq_valid is registered alongside the state it mirrors.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            dreq_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state      <= REQ;
                        dreq_valid <= 1'b1;
                    end
                end
                REQ: begin
                    if (dresp_addr_ok && dresp_data_ok) begin
                        if (count > CNT_W'(1)) begin
                            state      <= REQ;
                            dreq_valid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            dreq_valid <= 1'b0;
                        end
                    end else if (dresp_addr_ok) begin
                        state      <= WAIT;
                        dreq_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (dresp_data_ok) begin
                        if (count > CNT_W'(1)) begin
                            state      <= REQ;
                            dreq_valid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            dreq_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dreq_valid <= 1'b0;
                end
            endcase
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (!resetn)
        count <= CNT_W'(DEPTH));

    no_issue_when_empty: assert property (@(posedge clk) disable iff (!resetn)
        (state != IDLE) |-> (count != '0));

endmodule

// File: tb/tb_store_queue.sv
// Bench for store_queue: directed stores, a bus responder, and a monitor that
// compares each issued request against a scoreboard of hand-computed entries.
module tb_store_queue;
    import store_queue_pkg::*;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk;
    logic              resetn;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_addr;
    logic [31:0]       in_data;
    msize_t            in_msize;
    misalign_mem_t     in_memtype;
    logic              ades;
    logic              dreq_valid;
    logic [31:0]       dreq_addr;
    msize_t            dreq_size;
    logic [3:0]        dreq_strobe;
    logic [31:0]       dreq_data;
    logic              dresp_addr_ok;
    logic              dresp_data_ok;
    logic              empty;
    logic [CNT_W-1:0]  count;

    store_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_addr       (in_addr),
        .in_data       (in_data),
        .in_msize      (in_msize),
        .in_memtype    (in_memtype),
        .ades          (ades),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .empty         (empty),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_bad = 0;
    store_entry_t exp_q[$];

    // Bus responder controls
    logic manual = 1'b1;
    logic m_aok  = 1'b0;
    logic m_dok  = 1'b0;
    int   data_lat = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic store_entry_t mk(input logic [31:0] a, input msize_t sz,
                                        input logic [3:0] st, input logic [31:0] d);
        store_entry_t e;
        e.addr = a; e.size = sz; e.strobe = st; e.data = d;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one store for a single accepted cycle (waits, bounded, for in_ready).
    task automatic send(input logic [31:0] a, input logic [31:0] d, input msize_t sz,
                        input misalign_mem_t mt, input logic exp_ades, input store_entry_t exp_e);
        @(negedge clk);
        in_valid = 1'b1; in_addr = a; in_data = d; in_msize = sz; in_memtype = mt;
        #1;
        chk("ades", ades, exp_ades);
        if (!exp_ades) begin
            exp_q.push_back(exp_e);
            for (int i = 0; i < 40 && !in_ready; i++) begin
                @(negedge clk);
                #1;
            end
            if (!in_ready) chk("in_ready_timeout", 0, 1);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && !empty; i++) tick();
        chk("drain_empty", empty, 1);
        chk("scoreboard_left", exp_q.size(), 0);
    endtask

    // Responder: manual mode copies m_aok/m_dok; auto mode accepts and completes after data_lat.
    initial begin
        int pend;
        pend = -1;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn || manual) begin
                pend = -1;
                dresp_addr_ok = m_aok;
                dresp_data_ok = m_dok;
            end else begin
                dresp_addr_ok = 1'b0;
                dresp_data_ok = 1'b0;
                if (pend > 0) pend--;
                if (pend == 0) begin
                    dresp_data_ok = 1'b1;
                    pend = -1;
                end else if (pend < 0 && dreq_valid) begin
                    dresp_addr_ok = 1'b1;
                    if (data_lat == 0) dresp_data_ok = 1'b1;
                    else pend = data_lat;
                end
            end
        end
    end

    // Monitor: every cycle a request is shown it must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (resetn && dreq_valid) begin
                if (exp_q.size() == 0) begin
                    chk("dreq_unexpected", 1, 0);
                end else begin
                    chk("dreq", {dreq_addr, dreq_size, dreq_strobe, dreq_data}, exp_q[0]);
                    if (dresp_addr_ok) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_data = '0;
        in_msize = MSIZE4; in_memtype = NO_MISALIGN;
        repeat (3) tick();
        chk("rst_empty", empty, 1);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_dreq_valid", dreq_valid, 0);
        @(negedge clk);
        resetn = 1'b1;
        manual = 1'b0;
        data_lat = 0;

        // ades is gated by in_valid
        in_addr = 32'h3001; in_msize = MSIZE2;
        #1;
        chk("ades_idle", ades, 0);

        // SB: request appears one cycle after enqueue
        send(32'h1003, 32'hAABBCCDD, MSIZE1, NO_MISALIGN, 0,
             mk(32'h1003, MSIZE1, 4'b1000, 32'hDDDDDDDD));
        chk("sb_count", count, 1);
        chk("sb_not_yet", dreq_valid, 0);
        tick();
        chk("sb_rise", dreq_valid, 1);
        drain();

        // SWL / SWR lane placement
        send(32'h2001, 32'h11223344, MSIZE4, MEML, 0, mk(32'h2000, MSIZE4, 4'b0011, 32'h00001122));
        send(32'h2002, 32'h11223344, MSIZE4, MEMR, 0, mk(32'h2000, MSIZE4, 4'b1100, 32'h33440000));
        send(32'h2000, 32'h11223344, MSIZE4, MEML, 0, mk(32'h2000, MSIZE4, 4'b0001, 32'h00000011));
        send(32'h2003, 32'h11223344, MSIZE4, MEML, 0, mk(32'h2000, MSIZE4, 4'b1111, 32'h11223344));
        send(32'h2003, 32'h11223344, MSIZE4, MEMR, 0, mk(32'h2000, MSIZE4, 4'b1000, 32'h44000000));
        send(32'h2001, 32'h11223344, MSIZE4, MEMR, 0, mk(32'h2000, MSIZE4, 4'b1110, 32'h22334400));
        drain();

        // Misaligned SH/SW flagged and dropped
        send(32'h3001, 32'h0000BEEF, MSIZE2, NO_MISALIGN, 1, mk(0, MSIZE1, 0, 0));
        chk("ades_sh_count", count, 0);
        send(32'h3002, 32'h12345678, MSIZE4, NO_MISALIGN, 1, mk(0, MSIZE1, 0, 0));
        chk("ades_sw_count", count, 0);
        tick();
        chk("ades_no_req", dreq_valid, 0);

        // Aligned SH/SB/SW, with a slower bus completing in WAIT
        data_lat = 2;
        send(32'h3002, 32'h0000BEEF, MSIZE2, NO_MISALIGN, 0, mk(32'h3002, MSIZE2, 4'b1100, 32'hBEEFBEEF));
        send(32'h3000, 32'h1234ABCD, MSIZE2, NO_MISALIGN, 0, mk(32'h3000, MSIZE2, 4'b0011, 32'hABCDABCD));
        send(32'h1000, 32'hAABBCCDD, MSIZE1, NO_MISALIGN, 0, mk(32'h1000, MSIZE1, 4'b0001, 32'hDDDDDDDD));
        send(32'h5000, 32'hDEADBEEF, MSIZE4, NO_MISALIGN, 0, mk(32'h5000, MSIZE4, 4'b1111, 32'hDEADBEEF));
        drain();
        data_lat = 0;

        // Full queue with addr_ok withheld, then addr_ok at t and data_ok at t+3
        manual = 1'b1; m_aok = 1'b0; m_dok = 1'b0;
        send(32'h4000, 32'h01010101, MSIZE4, NO_MISALIGN, 0, mk(32'h4000, MSIZE4, 4'b1111, 32'h01010101));
        send(32'h4004, 32'h02020202, MSIZE4, NO_MISALIGN, 0, mk(32'h4004, MSIZE4, 4'b1111, 32'h02020202));
        chk("full_in_ready", in_ready, 0);
        chk("full_count", count, 2);
        chk("full_req", dreq_valid, 1);
        @(negedge clk);
        in_valid = 1'b1; in_addr = 32'h4008; in_data = 32'h03030303;
        in_msize = MSIZE4; in_memtype = NO_MISALIGN;
        exp_q.push_back(mk(32'h4008, MSIZE4, 4'b1111, 32'h03030303));
        tick();
        chk("full_blocked", count, 2);
        m_aok = 1'b1;
        tick();
        m_aok = 1'b0;
        chk("wait_t1_valid", dreq_valid, 0);
        chk("wait_t1_count", count, 2);
        chk("wait_t1_ready", in_ready, 0);
        tick();
        chk("wait_t2_valid", dreq_valid, 0);
        tick();
        chk("wait_t3_valid", dreq_valid, 0);
        chk("wait_t3_count", count, 2);
        m_dok = 1'b1;
        tick();
        m_dok = 1'b0;
        chk("deq_count", count, 1);
        chk("deq_in_ready", in_ready, 1);
        chk("next_req_t4", dreq_valid, 1);
        tick();
        in_valid = 1'b0;
        chk("third_accepted", count, 2);
        manual = 1'b0;
        drain();

        // Reset while WAIT holds one store and another is queued
        manual = 1'b1; m_aok = 1'b0; m_dok = 1'b0;
        send(32'h6000, 32'hA5A5A5A5, MSIZE4, NO_MISALIGN, 0, mk(32'h6000, MSIZE4, 4'b1111, 32'hA5A5A5A5));
        send(32'h6004, 32'h5A5A5A5A, MSIZE4, NO_MISALIGN, 0, mk(32'h6004, MSIZE4, 4'b1111, 32'h5A5A5A5A));
        m_aok = 1'b1;
        tick();
        m_aok = 1'b0;
        chk("pre_rst_valid", dreq_valid, 0);
        chk("pre_rst_count", count, 2);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", dreq_valid, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_ready", in_ready, 1);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        manual = 1'b0;
        repeat (3) tick();
        chk("post_rst_idle", dreq_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
